ram_arbiter: RTL
================

# ram_arbiter

Shares the single on-chip RAM port between the BIOS loader (boot-time command engine) and the CPU memory interface. Grants one access per enabled cycle, steers the selected requester's address/data/byte-enables onto the RAM, and returns one-cycle-latency read data with a per-requester valid pulse. Before boot completes only the BIOS may access RAM; after boot both requesters compete under the configured policy.

## Interface
- ADDR_WIDTH, 31, MSB index of address buses (bus width ADDR_WIDTH+1)
- DATA_WIDTH, 31, MSB index of data buses (bus width DATA_WIDTH+1)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- clk_en  in  1  cycle enable; no grant or state change when low
- i_booted  in  1  boot complete; 0 = BIOS-only access
- i_b_req / i_c_req  in  1  BIOS / CPU access request, held until granted
- i_b_we / i_c_we  in  1  1 = write, 0 = read
- i_b_addr / i_c_addr  in  ADDR_WIDTH+1  byte address
- i_b_wdata / i_c_wdata  in  DATA_WIDTH+1  write data
- i_b_be / i_c_be  in  4  write byte enables
- o_b_gnt / o_c_gnt  out  1  request accepted this cycle
- o_b_rvalid / o_c_rvalid  out  1  read data valid
- o_b_rdata / o_c_rdata  out  DATA_WIDTH+1  read data
- o_ram_read_req  out  1  RAM read strobe
- o_ram_write_enable  out  1  RAM write strobe
- o_ram_addr  out  ADDR_WIDTH+1  RAM address
- o_ram_write_data  out  DATA_WIDTH+1  RAM write data
- o_ram_byte_enable  out  4  RAM byte enables
- i_ram_read_data  in  DATA_WIDTH+1  RAM read data, valid one enabled cycle after o_ram_read_req

## Operation
- Eligible: BIOS = i_b_req; CPU = i_c_req & i_booted.
- Grant (combinational, gated by clk_en and rst high): at most one of o_b_gnt/o_c_gnt. Single eligible requester is granted. Both eligible: policy per Configuration.
- Granted requester's addr/wdata/be drive RAM buses; o_ram_read_req = gnt & ~we; o_ram_write_enable = gnt & we. No grant: strobes 0, buses 0.
- Writes complete in the grant cycle; no response.
- Read-owner FSM (states from ram_arb_owner_t): OWN_NONE, OWN_BIOS, OWN_CPU. On enabled edge: next = owner of the read granted this cycle, else OWN_NONE. Back-to-back reads pipeline: a new grant is legal in any state.
- o_x_rvalid = (state == OWN_x); o_x_rdata = i_ram_read_data when matching rvalid, else 0.
- i_booted falling mid-stream: pending CPU read still returns; new CPU requests ignored.

## Timing
- Reset (rst low, async): state OWN_NONE, last-grant register = CPU, all outputs 0.
- Grant latency 0 cycles from request (same cycle if eligible and winning).
- Read latency: rvalid asserted exactly one enabled cycle after the read grant, for one enabled cycle.
- clk_en low: grants and strobes 0, state and rvalid held; consumers sample rvalid only on enabled cycles.
- Reset asserted mid-read: rvalid drops immediately; data lost; no replay after release.
- Requester must hold req/we/addr/data stable until gnt; dropping req before gnt is allowed (request withdrawn).

## Configuration
- RAM_ARB_RR_EN defined: round-robin on contention; winner is the requester not recorded in last-grant register; register updates on every grant.
- Undefined: fixed priority, BIOS always wins contention; last-grant register absent.

## Structure
- Shared package bios_pkg: ram_arb_owner_t enum (OWN_NONE, OWN_BIOS, OWN_CPU), RAM_READ_LATENCY = 1 constant.
- One sub-module ram_arb_pick: two-input picker (eligible vector + last grant in, one-hot grant out), policy selected by RAM_ARB_RR_EN.

## Test plan
- i_booted=0, CPU read addr 0x10 and BIOS write 0x0000_00AA to 0x4 same cycle -> only o_b_gnt, o_ram_write_enable=1, o_ram_addr=0x4; o_c_gnt stays 0.
- i_booted=1, BIOS reads 0x8 (RAM returns 0xDEAD_BEEF) -> o_b_rvalid=1 one cycle later, o_b_rdata=0xDEAD_BEEF, o_c_rvalid=0.
- i_booted=1, both request reads continuously 4 cycles -> with RAM_ARB_RR_EN grants B,C,B,C; without, B,B,B,B.
- Back-to-back CPU reads 0x0,0x4 on consecutive cycles -> o_c_rvalid high two consecutive cycles with matching data.
- clk_en low for 3 cycles after a read grant -> rvalid held high and no new grants; returns one enabled cycle after clk_en rises.
- rst pulled low while OWN_CPU -> o_c_rvalid=0 immediately; after release first tie under RR goes to BIOS.

Source files
------------

// File: rtl/bios_pkg.sv
// Shared definitions for the boot subsystem: RAM read-owner encoding and read latency.
package bios_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_BIOS = 2'd1,
    OWN_CPU  = 2'd2
  } ram_arb_owner_t;

  localparam int unsigned RAM_READ_LATENCY = 1;

endpackage

// File: rtl/ram_arb_pick.sv
// Two-input grant picker (bit 0 = BIOS, bit 1 = CPU).
// RAM_ARB_RR_EN selects round-robin on contention; otherwise BIOS has fixed priority.
module ram_arb_pick (
  input  logic [1:0] elig_i,
  input  logic       last_c_i,
  output logic [1:0] gnt_o
);

`ifndef RAM_ARB_RR_EN
  logic unused_last_c;
  assign unused_last_c = last_c_i;
`endif

  always_comb begin
    gnt_o = '0;
    if (elig_i == 2'b11) begin
`ifdef RAM_ARB_RR_EN
      // Winner is whichever requester did not take the previous grant.
      gnt_o = last_c_i ? 2'b01 : 2'b10;
`else
      gnt_o = 2'b01;
`endif
    end else begin
      gnt_o = elig_i;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the RAM port between the BIOS loader and the CPU; one-cycle read return.
// RAM_ARB_RR_EN enables round-robin contention with a last-grant register.
module ram_arbiter
  import bios_pkg::*;
#(
  parameter int ADDR_WIDTH = 31,
  parameter int DATA_WIDTH = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic                  i_booted,
  input  logic                  i_b_req,
  input  logic                  i_b_we,
  input  logic [ADDR_WIDTH:0]   i_b_addr,
  input  logic [DATA_WIDTH:0]   i_b_wdata,
  input  logic [3:0]            i_b_be,
  input  logic                  i_c_req,
  input  logic                  i_c_we,
  input  logic [ADDR_WIDTH:0]   i_c_addr,
  input  logic [DATA_WIDTH:0]   i_c_wdata,
  input  logic [3:0]            i_c_be,
  output logic                  o_b_gnt,
  output logic                  o_c_gnt,
  output logic                  o_b_rvalid,
  output logic                  o_c_rvalid,
  output logic [DATA_WIDTH:0]   o_b_rdata,
  output logic [DATA_WIDTH:0]   o_c_rdata,
  output logic                  o_ram_read_req,
  output logic                  o_ram_write_enable,
  output logic [ADDR_WIDTH:0]   o_ram_addr,
  output logic [DATA_WIDTH:0]   o_ram_write_data,
  output logic [3:0]            o_ram_byte_enable,
  input  logic [DATA_WIDTH:0]   i_ram_read_data
);

  logic           en;
  logic [1:0]     elig;
  logic [1:0]     gnt;
  logic           last_c;
  logic           rd_b;
  logic           rd_c;
  ram_arb_owner_t state_q, state_d;

  assign en   = clk_en & rst;
  assign elig = {i_c_req & i_booted, i_b_req} & {2{en}};

  ram_arb_pick u_pick (
    .elig_i   (elig),
    .last_c_i (last_c),
    .gnt_o    (gnt)
  );

`ifdef RAM_ARB_RR_EN
  logic last_c_q, last_c_d;

  always_comb begin
    last_c_d = last_c_q;
    if (|gnt) last_c_d = gnt[1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_c_q <= 1'b1;
    else      last_c_q <= last_c_d;
  end

  assign last_c = last_c_q;
`else
  assign last_c = 1'b1;
`endif

  assign o_b_gnt = gnt[0];
  assign o_c_gnt = gnt[1];
  assign rd_b    = gnt[0] & ~i_b_we;
  assign rd_c    = gnt[1] & ~i_c_we;

  always_comb begin
    o_ram_read_req     = 1'b0;
    o_ram_write_enable = 1'b0;
    o_ram_addr         = '0;
    o_ram_write_data   = '0;
    o_ram_byte_enable  = '0;
    if (gnt[0]) begin
      o_ram_read_req     = ~i_b_we;
      o_ram_write_enable = i_b_we;
      o_ram_addr         = i_b_addr;
      o_ram_write_data   = i_b_wdata;
      o_ram_byte_enable  = i_b_be;
    end else if (gnt[1]) begin
      o_ram_read_req     = ~i_c_we;
      o_ram_write_enable = i_c_we;
      o_ram_addr         = i_c_addr;
      o_ram_write_data   = i_c_wdata;
      o_ram_byte_enable  = i_c_be;
    end
  end

  always_comb begin
    state_d = state_q;
    if (en) begin
      if (rd_b)      state_d = OWN_BIOS;
      else if (rd_c) state_d = OWN_CPU;
      else           state_d = OWN_NONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= OWN_NONE;
    else      state_q <= state_d;
  end

  assign o_b_rvalid = (state_q == OWN_BIOS);
  assign o_c_rvalid = (state_q == OWN_CPU);
  assign o_b_rdata  = o_b_rvalid ? i_ram_read_data : '0;
  assign o_c_rdata  = o_c_rvalid ? i_ram_read_data : '0;

endmodule
